// File: rtl/branch_tag_manager.sv
// Branch tag allocator and tracker: hands out speculative tags at decode, retires
// them in order once resolved, and squashes younger tags on a mispredict.
module branch_tag_manager #(
    parameter int NUM_TAGS   = 4,
    parameter int TAG_WIDTH  = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc_req,
    output logic                  alloc_grant,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  res_valid,
    input  logic [TAG_WIDTH-1:0]  res_tag,
    input  logic                  res_mispredict,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic [NUM_TAGS-1:0]   busy_mask,
    output logic                  full,
    output logic                  empty,
    output logic                  flush_valid,
    output logic [NUM_TAGS-1:0]   flush_mask,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);

    // state   | meaning
    // NORMAL  | allocation, resolution and retire all active
    // RECOVER | cycle after a mispredict; flush/redirect visible, no allocation

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    localparam logic [TAG_WIDTH:0] CNT_ONE  = (TAG_WIDTH+1)'(1);
    localparam logic [TAG_WIDTH:0] CNT_FULL = (TAG_WIDTH+1)'(NUM_TAGS);

    state_t                state, state_n;
    logic [NUM_TAGS-1:0]   valid, valid_n;
    logic [NUM_TAGS-1:0]   resolved, resolved_n;
    logic [TAG_WIDTH-1:0]  head, head_n;
    logic [TAG_WIDTH-1:0]  tail, tail_n;
    logic [TAG_WIDTH:0]    count, count_n;

    logic                  res_acc;
    logic                  mis_acc;
    logic                  retire;
    logic [TAG_WIDTH-1:0]  age_m;
    logic [TAG_WIDTH-1:0]  age_i;
    logic [NUM_TAGS-1:0]   squash;

    assign alloc_tag = tail;
    assign busy_mask = valid;

    always_comb begin
        res_acc     = res_valid & valid[res_tag] & ~resolved[res_tag];
        mis_acc     = res_acc & res_mispredict;
        alloc_grant = alloc_req & ~full & (state == NORMAL) & ~mis_acc;
        retire      = valid[head] & resolved[head] & ~mis_acc;
        age_m       = res_tag - head;

        // Younger than the mispredicted branch means strictly larger age from head.
        squash = '0;
        age_i  = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            age_i = TAG_WIDTH'(i) - head;
            if (valid[i] && (age_i > age_m)) begin
                squash[i] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_n    = valid;
        resolved_n = resolved;
        head_n     = head;
        tail_n     = tail;
        count_n    = count;

        if (res_acc) begin
            resolved_n[res_tag] = 1'b1;
        end

        if (mis_acc) begin
            valid_n = valid & ~squash;
            tail_n  = res_tag + TAG_WIDTH'(1);
            count_n = {1'b0, age_m} + CNT_ONE;
        end else begin
            if (retire) begin
                valid_n[head] = 1'b0;
                head_n        = head + TAG_WIDTH'(1);
            end
            if (alloc_grant) begin
                valid_n[tail]    = 1'b1;
                resolved_n[tail] = 1'b0;
                tail_n           = tail + TAG_WIDTH'(1);
            end
            if (alloc_grant && !retire) begin
                count_n = count + CNT_ONE;
            end else if (retire && !alloc_grant) begin
                count_n = count - CNT_ONE;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            NORMAL:  if (mis_acc) state_n = RECOVER;
            RECOVER: state_n = NORMAL;
            default: state_n = NORMAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= NORMAL;
            valid          <= '0;
            resolved       <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            flush_valid    <= 1'b0;
            flush_mask     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_n;
            valid          <= valid_n;
            resolved       <= resolved_n;
            head           <= head_n;
            tail           <= tail_n;
            count          <= count_n;
            full           <= (count_n == CNT_FULL);
            empty          <= (count_n == '0);
            flush_valid    <= mis_acc;
            flush_mask     <= mis_acc ? squash : '0;
            redirect_valid <= mis_acc;
            redirect_pc    <= mis_acc ? res_target : '0;
        end
    end

endmodule

// File: tb/tb_branch_tag_manager.sv
// Directed vector bench for branch_tag_manager: per-cycle table of stimulus and
// expected grant/registered outputs, plus a reset-during-recover sequence.
module tb_branch_tag_manager;

    logic        clock;
    logic        reset;
    logic        alloc_req;
    logic        alloc_grant;
    logic [1:0]  alloc_tag;
    logic        res_valid;
    logic [1:0]  res_tag;
    logic        res_mispredict;
    logic [31:0] res_target;
    logic [3:0]  busy_mask;
    logic        full;
    logic        empty;
    logic        flush_valid;
    logic [3:0]  flush_mask;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    branch_tag_manager #(.NUM_TAGS(4), .TAG_WIDTH(2), .ADDR_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_grant    (alloc_grant),
        .alloc_tag      (alloc_tag),
        .res_valid      (res_valid),
        .res_tag        (res_tag),
        .res_mispredict (res_mispredict),
        .res_target     (res_target),
        .busy_mask      (busy_mask),
        .full           (full),
        .empty          (empty),
        .flush_valid    (flush_valid),
        .flush_mask     (flush_mask),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic        areq;
        logic        rv;
        logic [1:0]  rtag;
        logic        rmis;
        logic [31:0] rtgt;
        logic        e_grant;
        logic [1:0]  e_tag;
        logic [3:0]  e_busy;
        logic        e_full;
        logic        e_empty;
        logic        e_fv;
        logic [3:0]  e_fmask;
        logic        e_rv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic areq, input logic rv, input logic [1:0] rtag,
                       input logic rmis, input logic [31:0] rtgt, input logic e_grant,
                       input logic [1:0] e_tag, input logic [3:0] e_busy, input logic e_full,
                       input logic e_empty, input logic e_fv, input logic [3:0] e_fmask,
                       input logic e_rv, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.areq = areq; v.rv = rv; v.rtag = rtag; v.rmis = rmis; v.rtgt = rtgt;
        v.e_grant = e_grant; v.e_tag = e_tag; v.e_busy = e_busy; v.e_full = e_full;
        v.e_empty = e_empty; v.e_fv = e_fv; v.e_fmask = e_fmask; v.e_rv = e_rv; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    initial begin
        //   rst areq rv tag mis target        grant tag busy     full empty fv fmask   rv pc
        // four allocations, then a fifth refused while full
        add(0, 1, 0, 0, 0, 32'h0,          1, 0, 4'b0001, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 1, 4'b0011, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 2, 4'b0111, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 3, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        // resolve tag 0 correct with alloc held: retire next cycle, regrant tag 0 after
        add(0, 1, 1, 0, 0, 32'h0,          0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          0, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        // reset, fill, mispredict tag 1
        add(1, 0, 0, 0, 0, 32'h0,          0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 0, 4'b0001, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 1, 4'b0011, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 2, 4'b0111, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 3, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 1, 1, 1, 32'h0000_1000,  0, 0, 4'b0011, 0, 0, 1, 4'b1100, 1, 32'h0000_1000);
        add(0, 1, 0, 0, 0, 32'h0,          0, 2, 4'b0011, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 2, 4'b0111, 0, 0, 0, 4'b0000, 0, 32'h0);
        // mispredict on youngest (tag 2) with a same-cycle request
        add(0, 1, 1, 2, 1, 32'h0000_2468,  0, 3, 4'b0111, 0, 0, 1, 4'b0000, 1, 32'h0000_2468);
        add(0, 0, 0, 0, 0, 32'h0,          0, 3, 4'b0111, 0, 0, 0, 4'b0000, 0, 32'h0);
        // reset, fill, out-of-order resolves, ignored resolves
        add(1, 0, 0, 0, 0, 32'h0,          0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 0, 4'b0001, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 1, 4'b0011, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 2, 4'b0111, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 3, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 1, 3, 0, 32'h0,          0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 1, 0, 1, 32'h0000_dead,  0, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 0, 1, 3, 1, 32'h0000_beef,  0, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,          1, 0, 4'b1111, 1, 0, 0, 4'b0000, 0, 32'h0);

        reset          = 1'b1;
        alloc_req      = 1'b0;
        res_valid      = 1'b0;
        res_tag        = '0;
        res_mispredict = 1'b0;
        res_target     = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy",  busy_mask,   4'b0000);
        chk("rst_empty", empty,       1'b1);
        chk("rst_full",  full,        1'b0);
        chk("rst_flush", flush_valid, 1'b0);
        chk("rst_redir", redirect_valid, 1'b0);
        chk("rst_tag",   alloc_tag,   2'd0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            reset          = vecs[k].rst;
            alloc_req      = vecs[k].areq;
            res_valid      = vecs[k].rv;
            res_tag        = vecs[k].rtag;
            res_mispredict = vecs[k].rmis;
            res_target     = vecs[k].rtgt;
            #4;
            chk($sformatf("v%0d_grant", k), alloc_grant, vecs[k].e_grant);
            chk($sformatf("v%0d_tag", k),   alloc_tag,   vecs[k].e_tag);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_busy", k),  busy_mask,      vecs[k].e_busy);
            chk($sformatf("v%0d_full", k),  full,           vecs[k].e_full);
            chk($sformatf("v%0d_empty", k), empty,          vecs[k].e_empty);
            chk($sformatf("v%0d_fv", k),    flush_valid,    vecs[k].e_fv);
            chk($sformatf("v%0d_rv", k),    redirect_valid, vecs[k].e_rv);
            if (vecs[k].e_fv) chk($sformatf("v%0d_fmask", k), flush_mask, vecs[k].e_fmask);
            if (vecs[k].e_rv) chk($sformatf("v%0d_pc", k),    redirect_pc, vecs[k].e_pc);
        end

        // reset asserted during the RECOVER cycle clears the pulse immediately
        reset          = 1'b0;
        res_valid      = 1'b0;
        res_mispredict = 1'b0;
        alloc_req      = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        alloc_req = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("seq_busy2", busy_mask, 4'b0011);
        alloc_req      = 1'b0;
        res_valid      = 1'b1;
        res_tag        = 2'd0;
        res_mispredict = 1'b1;
        res_target     = 32'h0000_0055;
        @(posedge clock);
        #1;
        res_valid      = 1'b0;
        res_mispredict = 1'b0;
        chk("seq_fv",    flush_valid,    1'b1);
        chk("seq_fmask", flush_mask,     4'b0010);
        chk("seq_rv",    redirect_valid, 1'b1);
        chk("seq_pc",    redirect_pc,    32'h0000_0055);
        reset = 1'b1;
        #1;
        chk("seq_rst_fv",    flush_valid,    1'b0);
        chk("seq_rst_rv",    redirect_valid, 1'b0);
        chk("seq_rst_busy",  busy_mask,      4'b0000);
        chk("seq_rst_empty", empty,          1'b1);
        #2;
        reset     = 1'b0;
        alloc_req = 1'b1;
        #1;
        chk("seq_post_grant", alloc_grant, 1'b1);
        chk("seq_post_tag",   alloc_tag,   2'd0);
        @(posedge clock);
        #1;
        alloc_req = 1'b0;
        chk("seq_post_busy", busy_mask, 4'b0001);
        chk("seq_post_fv",   flush_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_tag_manager.md
Name: branch_tag_manager

Overview:
- Allocates speculative branch tags to branches at decode and tracks every in-flight branch until the branch resolver reports its outcome.
- On a mispredict, squashes all younger tags and drives a one-cycle flush mask and redirect PC to the front end and issue logic.
- Sits between decode/issue and the Execute-stage branch resolver. It is the sole owner of the branch-tag resource.

Parameters:
- NUM_TAGS, 4, number of in-flight branch tags; power of two, minimum 2.
- TAG_WIDTH, 2, equal to log2(NUM_TAGS).
- ADDR_WIDTH, 32, width of the redirect PC.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alloc_req  input  1  decode holds a branch that needs a tag.
- alloc_grant  output  1  combinational; tag granted this cycle.
- alloc_tag  output  TAG_WIDTH  tag granted; equals the tail pointer.
- res_valid  input  1  resolver outcome is valid this cycle.
- res_tag  input  TAG_WIDTH  tag being resolved.
- res_mispredict  input  1  branch was mispredicted.
- res_target  input  ADDR_WIDTH  correct next PC for a mispredicted branch.
- busy_mask  output  NUM_TAGS  registered; bit i set while tag i is allocated.
- full  output  1  registered; count equals NUM_TAGS.
- empty  output  1  registered; count equals 0.
- flush_valid  output  1  registered one-cycle squash pulse.
- flush_mask  output  NUM_TAGS  tags squashed; valid when flush_valid is high.
- redirect_valid  output  1  registered one-cycle redirect pulse.
- redirect_pc  output  ADDR_WIDTH  redirect target; valid when redirect_valid is high.

Behaviour:
- State per tag: valid[i] and resolved[i]. Pointers head and tail, each TAG_WIDTH bits, wrap modulo NUM_TAGS. count is TAG_WIDTH+1 bits.
- Reset, asynchronous:
  - Clears all valid, resolved, head, tail and count.
  - Forces state to NORMAL.
  - All outputs return to 0 except empty, which is 1.
  - Reset takes effect mid-flush with no residual pulse.
- Age is defined as age(t) = (t - head) mod NUM_TAGS.
- FSM states: NORMAL and RECOVER.
  - NORMAL to RECOVER on an accepted mispredict.
  - RECOVER to NORMAL unconditionally after 1 cycle.
- alloc_grant = alloc_req & ~full & (state == NORMAL) & ~(accepted mispredict this cycle).
  - On grant: valid[tail] is set, resolved[tail] is cleared, tail increments and count increments.
  - When full, there is no bypass. A retire in the same cycle does not enable a grant.
- Resolution is accepted only when res_valid & valid[res_tag] & ~resolved[res_tag].
  - Resolves to an unallocated tag are ignored, with no error flag.
  - Duplicate resolves are ignored.
  - An accepted resolve sets resolved[res_tag].
- Accepted mispredict at tag m:
  - Clears valid for every valid tag with age > age(m). flush_mask is registered to exactly that set, and may be all-zero if m is the youngest.
  - tail becomes m+1 and count becomes age(m)+1.
  - flush_valid, redirect_valid and redirect_pc (= res_target) are registered. They are high for exactly the next cycle, which is the RECOVER cycle.
  - A grant in the same cycle is suppressed. Mispredict wins over alloc.
- Retire:
  - Applies when valid[head] & resolved[head], and no accepted mispredict occurs this cycle.
  - Clears valid[head], increments head and decrements count. At most one retire per cycle.
  - Retire and grant in the same cycle leave count unchanged.
- Resolves are accepted during RECOVER for surviving tags. Retire also continues during RECOVER.
- An accepted correct-prediction resolve has no output side effects beyond busy_mask after retire.
- Latency:
  - grant is combinational.
  - busy_mask, full and empty update 1 cycle after the event.
  - flush and redirect assert 1 cycle after the accepted mispredict.

Test Plan:
- Reset, then 4 consecutive alloc_req:
  - Grants tags 0,1,2,3 on consecutive cycles, then full=1 and busy_mask=1111.
  - A 5th request gets alloc_grant=0.
- Full FIFO; resolve tag 0 correct, and alloc_req held:
  - Tag 0 retires one cycle later.
  - The following cycle grants tag 0 again, showing wrap-around; busy_mask=1111.
- Tags 0..3 allocated; resolve tag 1 mispredict with target 0x0000_1000:
  - Next cycle flush_valid=1, flush_mask=1100, redirect_pc=0x1000.
  - tail becomes 2; alloc is blocked one cycle, then the next grant is tag 2.
- Mispredict on the youngest tag:
  - flush_valid=1 with flush_mask=0000, and redirect still asserted.
  - A same-cycle alloc_req is not granted.
- Resolve tag 3 out of order (tags 0..3 busy), then tag 0:
  - No retire until tag 0 resolves.
  - Then head advances 0 to 1 and stops at 1.
  - Resolve to a non-busy tag changes nothing.
- Assert reset during the RECOVER cycle:
  - flush_valid, redirect_valid and busy_mask go to 0 immediately.
  - empty=1, and the first grant after reset is tag 0.
